// File: rtl/up_counter_ctrl_if.sv
// ----------------------------------------------------------------------------
// up_counter_ctrl_if
//  Bundles the button/feedback inputs and the counter-control outputs of
//  up_counter_ctrl so the controller and its surroundings share one port.
//
//  Signals
//   start_stop  1      1-cycle pulse: IDLE->RUN, RUN->PAUSE, PAUSE->RUN
//   clear       1      1-cycle pulse: clear counter, return to IDLE
//   count_in    WIDTH  current counter value fed back from the datapath
//   cnt_inc     1      registered 1-cycle increment enable
//   cnt_clr     1      registered 1-cycle synchronous clear
//   wrapped     1      1-cycle pulse when the terminal->0 wrap is issued
//   running     1      high while state == RUN
//   state       2      00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   disp_count  WIDTH  value for the BCD display path
//   lap         1      (LAP_EN) 1-cycle pulse: toggle lap hold
//   lap_hold    1      (LAP_EN) high while the display is frozen
//
//  Modports
//   master  upstream side: drives the pulses and count feedback
//   slave   controller side (up_counter_ctrl)
//
//  Configuration macro: LAP_EN adds the lap / lap_hold signals.
// ----------------------------------------------------------------------------
interface up_counter_ctrl_if #(
    parameter int WIDTH = 12
);
    logic             start_stop;
    logic             clear;
    logic [WIDTH-1:0] count_in;
    logic             cnt_inc;
    logic             cnt_clr;
    logic             wrapped;
    logic             running;
    logic [1:0]       state;
    logic [WIDTH-1:0] disp_count;
`ifdef LAP_EN
    logic             lap;
    logic             lap_hold;

    modport master (
        output start_stop, clear, count_in, lap,
        input  cnt_inc, cnt_clr, wrapped, running, state, disp_count, lap_hold
    );

    modport slave (
        input  start_stop, clear, count_in, lap,
        output cnt_inc, cnt_clr, wrapped, running, state, disp_count, lap_hold
    );
`else
    modport master (
        output start_stop, clear, count_in,
        input  cnt_inc, cnt_clr, wrapped, running, state, disp_count
    );

    modport slave (
        input  start_stop, clear, count_in,
        output cnt_inc, cnt_clr, wrapped, running, state, disp_count
    );
`endif
endinterface

// File: rtl/up_counter_ctrl.sv
// ----------------------------------------------------------------------------
// up_counter_ctrl
//  Run/pause/clear sequencer for the 12-bit display up-counter on the BCD
//  board. Converts single-cycle button pulses into a prescaled stream of
//  increment enables, and handles the terminal value either by wrapping to 0
//  or, in one-shot mode, by stopping in DONE.
//
//  Parameters
//   WIDTH     counter width (count_in, disp_count, lap register)
//   PRESCALE  clk cycles per count tick (>= 2)
//   TERMINAL  last count value before wrap/stop (< 2**WIDTH)
//   ONE_SHOT  0: wrap TERMINAL->0 and continue; 1: stop in DONE at TERMINAL
//
//  Ports
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   up_counter_ctrl_if.slave: start_stop, clear, count_in in;
//         cnt_inc, cnt_clr, wrapped, running, state, disp_count out
//         (plus lap in / lap_hold out with LAP_EN)
//
//  Configuration macro: LAP_EN adds a WIDTH-bit lap register that can freeze
//  disp_count while counting continues underneath.
// ----------------------------------------------------------------------------
module up_counter_ctrl #(
    parameter int WIDTH    = 12,
    parameter int PRESCALE = 10_000_000,
    parameter int TERMINAL = 4095,
    parameter int ONE_SHOT = 0
) (
    input  logic              clk,
    input  logic              rst,
    up_counter_ctrl_if.slave  bus
);

    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] TERM     = WIDTH'(TERMINAL);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          inc_q, inc_d;
    logic          clr_q, clr_d;
    logic          wrap_q, wrap_d;
    logic          tick;
    logic          at_terminal;

    assign tick        = (state_q == RUN) && (pre_q == PRE_LAST);
    assign at_terminal = (bus.count_in == TERM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pre_q   <= '0;
            inc_q   <= 1'b0;
            clr_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            inc_q   <= inc_d;
            clr_q   <= clr_d;
            wrap_q  <= wrap_d;
        end
    end

    // clear wins over everything; otherwise the tick is resolved first so a
    // start_stop arriving on a tick cycle still lets that tick through.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        inc_d   = 1'b0;
        clr_d   = 1'b0;
        wrap_d  = 1'b0;

        // The prescaler only advances in RUN; holding it in PAUSE keeps the
        // tick phase across a pause/resume.
        case (state_q)
            IDLE:  pre_d = '0;
            RUN:   pre_d = tick ? '0 : pre_q + 1'b1;
            PAUSE: pre_d = pre_q;
            DONE:  pre_d = '0;
        endcase

        if (bus.clear) begin
            state_d = IDLE;
            pre_d   = '0;
            clr_d   = 1'b1;
        end else begin
            if (tick) begin
                if (!at_terminal) begin
                    inc_d = 1'b1;
                end else if (ONE_SHOT == 0) begin
                    clr_d  = 1'b1;
                    wrap_d = 1'b1;
                end else begin
                    state_d = DONE;
                    pre_d   = '0;
                end
            end

            if (bus.start_stop) begin
                case (state_q)
                    IDLE: begin
                        state_d = RUN;
                        pre_d   = '0;
                    end
                    // Reaching DONE on this same tick takes precedence.
                    RUN: begin
                        if (state_d != DONE) begin
                            state_d = PAUSE;
                        end
                    end
                    PAUSE:   state_d = RUN;
                    default: ;
                endcase
            end
        end
    end

    assign bus.cnt_inc = inc_q;
    assign bus.cnt_clr = clr_q;
    assign bus.wrapped = wrap_q;
    assign bus.running = (state_q == RUN);
    assign bus.state   = state_q;

`ifdef LAP_EN
    logic             lap_hold_q;
    logic [WIDTH-1:0] lap_reg_q;

    // Lap toggles between capturing the live count and releasing the
    // display; it is meaningless before counting has started.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_hold_q <= 1'b0;
            lap_reg_q  <= '0;
        end else if (bus.clear) begin
            lap_hold_q <= 1'b0;
        end else if (bus.lap && (state_q != IDLE)) begin
            if (!lap_hold_q) begin
                lap_reg_q  <= bus.count_in;
                lap_hold_q <= 1'b1;
            end else begin
                lap_hold_q <= 1'b0;
            end
        end
    end

    assign bus.lap_hold   = lap_hold_q;
    assign bus.disp_count = lap_hold_q ? lap_reg_q : bus.count_in;
`else
    assign bus.disp_count = bus.count_in;
`endif

endmodule

// File: tb/tb_up_counter_ctrl.sv
// ----------------------------------------------------------------------------
// tb_up_counter_ctrl
//  Drives two controllers (wrap mode and one-shot mode) with the same button
//  pulses; each has its own behavioural counter datapath closing the
//  count_in loop. A reference model predicts, per cycle, the visible state
//  and display value and the increment/clear/wrap pulses; a negedge monitor
//  pops those predictions and compares them with what each DUT presents.
// ----------------------------------------------------------------------------
module tb_up_counter_ctrl;

    localparam int W = 12;
    localparam int P = 4;
    localparam int T = 5;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    localparam int K_INC  = 0;
    localparam int K_WRAP = 1;
    localparam int K_CLR  = 2;
    localparam int K_BAD  = 3;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    typedef struct {
        int st;
        int disp;
        int lh;
        int cyc;
    } st_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ss  = 1'b0;
    logic clr = 1'b0;
    logic lapv = 1'b0;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    ev_t evQ[2][$];
    st_t stQ[2][$];

    // Reference model: what the board should be doing, per controller.
    int mState[2];
    int mRunCycles[2];
    int mCount[2];
    int mLapReg[2];
    bit mPendInc[2];
    bit mPendClr[2];
    bit mLapHold[2];

    logic [W-1:0] cnt0, cnt1;

    up_counter_ctrl_if #(.WIDTH(W)) bus0 ();
    up_counter_ctrl_if #(.WIDTH(W)) bus1 ();

    up_counter_ctrl #(.WIDTH(W), .PRESCALE(P), .TERMINAL(T), .ONE_SHOT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    up_counter_ctrl #(.WIDTH(W), .PRESCALE(P), .TERMINAL(T), .ONE_SHOT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    assign bus0.start_stop = ss;
    assign bus0.clear      = clr;
    assign bus0.count_in   = cnt0;
    assign bus1.start_stop = ss;
    assign bus1.clear      = clr;
    assign bus1.count_in   = cnt1;
`ifdef LAP_EN
    assign bus0.lap = lapv;
    assign bus1.lap = lapv;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Counter datapaths driven by the controllers' pulses.
    always @(posedge clk or posedge rst) begin
        if (rst) cnt0 <= '0;
        else if (bus0.cnt_clr) cnt0 <= '0;
        else if (bus0.cnt_inc) cnt0 <= cnt0 + 1'b1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) cnt1 <= '0;
        else if (bus1.cnt_clr) cnt1 <= '0;
        else if (bus1.cnt_inc) cnt1 <= cnt1 + 1'b1;
    end

    task automatic chk(string name, int d, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d cycle %0d: got %0d, expected %0d", name, d, cyc, act, exp);
        end
    endtask

    task automatic failNow(string name, int d, int info);
        checks++;
        errors++;
        $display("[TB] FAIL %s dut%0d cycle %0d: got event, expected none (ref %0d)", name, d, cyc, info);
    endtask

    task automatic sample(input int d, output logic inc, output logic clo, output logic wrp,
                          output logic run, output logic [1:0] st, output logic [W-1:0] disp,
                          output logic lh);
        lh = 1'b0;
        if (d == 0) begin
            inc = bus0.cnt_inc; clo = bus0.cnt_clr; wrp = bus0.wrapped;
            run = bus0.running; st = bus0.state; disp = bus0.disp_count;
`ifdef LAP_EN
            lh = bus0.lap_hold;
`endif
        end else begin
            inc = bus1.cnt_inc; clo = bus1.cnt_clr; wrp = bus1.wrapped;
            run = bus1.running; st = bus1.state; disp = bus1.disp_count;
`ifdef LAP_EN
            lh = bus1.lap_hold;
`endif
        end
    endtask

    task automatic pushEv(int d, int kind);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc + 1;
        evQ[d].push_back(e);
    endtask

    task automatic pushSt(int d, int c);
        st_t s;
        s.st   = mState[d];
        s.disp = mLapHold[d] ? mLapReg[d] : mCount[d];
        s.lh   = int'(mLapHold[d]);
        s.cyc  = c;
        stQ[d].push_back(s);
    endtask

    // Advance the model across the coming clock edge for the given inputs.
    task automatic modelStep(int d, bit s, bit c, bit l, bit r);
        int  newCount;
        int  st0;
        bit  tick;
        bit  oneShot;
        oneShot = (d == 1);
        if (r) begin
            mState[d] = S_IDLE; mRunCycles[d] = 0; mCount[d] = 0; mLapReg[d] = 0;
            mPendInc[d] = 0; mPendClr[d] = 0; mLapHold[d] = 0;
            pushSt(d, cyc + 1);
            return;
        end
        newCount = mPendClr[d] ? 0 : (mPendInc[d] ? (mCount[d] + 1) % (1 << W) : mCount[d]);
        mPendInc[d] = 0;
        mPendClr[d] = 0;
        st0 = mState[d];
        if (c) begin
            mState[d] = S_IDLE;
            mRunCycles[d] = 0;
            mPendClr[d] = 1;
            mLapHold[d] = 0;
            pushEv(d, K_CLR);
        end else begin
            tick = (st0 == S_RUN) && (mRunCycles[d] % P == P - 1);
            if (st0 == S_RUN) mRunCycles[d]++;
            if (tick) begin
                if (mCount[d] != T) begin
                    mPendInc[d] = 1;
                    pushEv(d, K_INC);
                end else if (!oneShot) begin
                    mPendClr[d] = 1;
                    pushEv(d, K_WRAP);
                end else begin
                    mState[d] = S_DONE;
                    mRunCycles[d] = 0;
                end
            end
            if (s) begin
                if (st0 == S_IDLE) begin
                    mState[d] = S_RUN;
                    mRunCycles[d] = 0;
                end else if (st0 == S_RUN && mState[d] != S_DONE) begin
                    mState[d] = S_PAUSE;
                end else if (st0 == S_PAUSE) begin
                    mState[d] = S_RUN;
                end
            end
`ifdef LAP_EN
            if (l && st0 != S_IDLE) begin
                if (!mLapHold[d]) begin
                    mLapReg[d]  = mCount[d];
                    mLapHold[d] = 1;
                end else begin
                    mLapHold[d] = 0;
                end
            end
`else
            if (l) mLapHold[d] = mLapHold[d];
`endif
        end
        mCount[d] = newCount;
        pushSt(d, cyc + 1);
    endtask

    // Asynchronous reset lands between edges: the current cycle's
    // predictions no longer apply and everything must read zero at once.
    task automatic resetNow();
        logic inc, clo, wrp, run, lh;
        logic [1:0] st;
        logic [W-1:0] disp;
        st_t s;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            while (evQ[d].size() > 0 && evQ[d][evQ[d].size()-1].cyc >= cyc) void'(evQ[d].pop_back());
            if (stQ[d].size() > 0 && stQ[d][stQ[d].size()-1].cyc == cyc) void'(stQ[d].pop_back());
            s.st = S_IDLE; s.disp = 0; s.lh = 0; s.cyc = cyc;
            stQ[d].push_back(s);
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            sample(d, inc, clo, wrp, run, st, disp, lh);
            chk("rst_cnt_inc", d, int'(inc), 0);
            chk("rst_cnt_clr", d, int'(clo), 0);
            chk("rst_wrapped", d, int'(wrp), 0);
            chk("rst_running", d, int'(run), 0);
            chk("rst_state", d, int'(st), S_IDLE);
            chk("rst_disp", d, int'(disp), 0);
        end
    endtask

    task automatic applyStimulus(bit s, bit c, bit l, bit r);
        @(posedge clk);
        #2;
        if (r && !rst) resetNow();
        else rst = r;
        ss   = s;
        clr  = c;
        lapv = l;
        for (int d = 0; d < 2; d++) modelStep(d, s, c, l, r);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0);
    endtask

    task automatic checkOutput(int d);
        logic inc, clo, wrp, run, lh;
        logic [1:0] st;
        logic [W-1:0] disp;
        st_t s;
        ev_t e;
        int  kind;
        sample(d, inc, clo, wrp, run, st, disp, lh);
        while (stQ[d].size() > 0 && stQ[d][0].cyc < cyc) begin
            s = stQ[d].pop_front();
            failNow("stale_state_prediction", d, s.cyc);
        end
        if (stQ[d].size() > 0 && stQ[d][0].cyc == cyc) begin
            s = stQ[d].pop_front();
            chk("state", d, int'(st), s.st);
            chk("running", d, int'(run), int'(s.st == S_RUN));
            chk("disp_count", d, int'(disp), s.disp);
`ifdef LAP_EN
            chk("lap_hold", d, int'(lh), s.lh);
`endif
        end
        chk("inc_clr_exclusive", d, int'(inc && clo), 0);
        if (inc || clo || wrp) begin
            kind = inc ? K_INC : ((clo && wrp) ? K_WRAP : (clo ? K_CLR : K_BAD));
            if (evQ[d].size() == 0) begin
                failNow("unexpected_pulse", d, kind);
            end else begin
                e = evQ[d].pop_front();
                chk("pulse_kind", d, kind, e.kind);
                chk("pulse_cycle", d, cyc, e.cyc);
            end
        end
        while (evQ[d].size() > 0 && evQ[d][0].cyc <= cyc) begin
            e = evQ[d].pop_front();
            chk("missed_pulse", d, -1, e.kind);
        end
    endtask

    always @(negedge clk) begin
        checkOutput(0);
        checkOutput(1);
    end

    // Advance until dut0's next edge is a tick seen with the given count.
    task automatic waitTickAt(int count, output bit found);
        found = 0;
        for (int i = 0; i < 60; i++) begin
            if (mState[0] == S_RUN && (mRunCycles[0] % P == P - 1) && mCount[0] == count) begin
                found = 1;
                break;
            end
            applyStimulus(0, 0, 0, 0);
        end
        if (!found) chk("wait_tick_timeout", 0, 0, 1);
    endtask

    initial begin
        bit found;
        for (int d = 0; d < 2; d++) begin
            mState[d] = S_IDLE; mRunCycles[d] = 0; mCount[d] = 0; mLapReg[d] = 0;
            mPendInc[d] = 0; mPendClr[d] = 0; mLapHold[d] = 0;
        end

        repeat (3) applyStimulus(0, 0, 0, 1);
        idle(2);

        // Run past the terminal: dut0 wraps, dut1 stops in DONE.
        applyStimulus(1, 0, 0, 0);
        idle(34);
        // Pause dut0; dut1 in DONE must ignore it.
        applyStimulus(1, 0, 0, 0);
        idle(6);
        applyStimulus(1, 0, 0, 0);
        idle(10);
        applyStimulus(0, 1, 0, 0);
        idle(3);

        // Pause on the tick that moves count 2 -> 3, then resume.
        applyStimulus(1, 0, 0, 0);
        waitTickAt(2, found);
        if (found) applyStimulus(1, 0, 0, 0);
        idle(5);
        applyStimulus(1, 0, 0, 0);
        idle(12);

        // clear and start_stop together while running.
        applyStimulus(1, 1, 0, 0);
        idle(3);

        // Reset in the middle of a prescale period.
        applyStimulus(1, 0, 0, 0);
        idle(6);
        applyStimulus(0, 0, 0, 1);
        idle(2);

`ifdef LAP_EN
        // Freeze the display at 3 while counting reaches the terminal.
        applyStimulus(0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0);
        waitTickAt(3, found);
        applyStimulus(0, 0, 1, 0);
        idle(12);
        applyStimulus(0, 0, 1, 0);
        idle(3);
        applyStimulus(0, 0, 1, 0);
        idle(2);
        applyStimulus(0, 1, 0, 0);
        idle(3);
`endif

        // Randomised button activity.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 11) == 0, $urandom_range(0, 49) == 0,
                          $urandom_range(0, 9) == 0, $urandom_range(0, 149) == 0);
        end
        applyStimulus(0, 0, 0, 0);
        idle(2);

        @(posedge clk);
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("leftover_pulses", d, evQ[d].size(), 0);
            chk("leftover_states", d, stQ[d].size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
